// File: rtl/cdiv_arb_pkg.sv
// Shared types and constants for the complex-divider arbiter.
package cdiv_arb_pkg;

   localparam int NUM_REQ_MAX = 8;
   localparam int STATUS_W    = 5;
   localparam int OPERAND_W   = 4 * 64;
   localparam int RESULT_W    = 2 * 64;

   // {b2, a2, b1, a1} and {b, a}, IEEE doubles
   typedef logic [3:0][63:0] operand_t;
   typedef logic [1:0][63:0] result_t;

   typedef logic [$clog2(NUM_REQ_MAX)-1:0] req_id_t;

endpackage

// File: rtl/cdiv_id_fifo.sv
// In-order FIFO of requester IDs for divisions in flight.
// DEPTH must be a power of two so the pointers wrap naturally.
module cdiv_id_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // Pointer and occupancy update; clear wins over push/pop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once counted valid
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/cdiv_arbiter.sv
// Round-robin arbiter sharing one complex_div between NUM_REQ requesters.
// Results are steered back to their issuer via an in-order ID FIFO.
// Optional feature macro: CDIV_ARB_STATS_EN adds per-requester accept
// counters on acc_cnt_o.
module cdiv_arbiter
   import cdiv_arb_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NUM_REQ*OPERAND_W-1:0]   req_operands_i,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic [RESULT_W-1:0]            rsp_result_o,
   output logic [STATUS_W-1:0]            rsp_status_o,
   output logic [NUM_REQ-1:0]             rsp_valid_o,
   input  logic [NUM_REQ-1:0]             rsp_ready_i,
   output logic [OPERAND_W-1:0]           div_operands_o,
   output logic                           div_in_valid_o,
   input  logic                           div_in_ready_i,
   input  logic [RESULT_W-1:0]            div_result_i,
   input  logic [STATUS_W-1:0]            div_status_i,
   input  logic                           div_out_valid_i,
   output logic                           div_out_ready_o,
   input  logic                           div_busy_i,
   input  logic                           flush_i,
   output logic                           div_flush_o,
   output logic                           busy_o,
   output logic                           err_o
`ifdef CDIV_ARB_STATS_EN
   ,
   output logic [NUM_REQ*32-1:0]          acc_cnt_o
`endif
);

   req_id_t  rr_q;
   req_id_t  hold_id_q;
   logic     hold_q;
   logic     err_q;
   req_id_t  grant;
   req_id_t  head_id;
   logic     fifo_full;
   logic     fifo_empty;
   logic     issue;
   logic     accept;
   logic     pop;
   logic     orphan;
   operand_t sel_ops;

   // First valid requester at or after ptr, wrapping around
   function automatic req_id_t rr_pick(req_id_t ptr, logic [NUM_REQ-1:0] valid);
      req_id_t pick;
      logic    found;
      pick  = ptr;
      found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && valid[j] && (j >= int'(ptr))) begin
            pick  = req_id_t'(j);
            found = 1'b1;
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && valid[j]) begin
            pick  = req_id_t'(j);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign grant          = hold_q ? hold_id_q : rr_pick(rr_q, req_valid_i);
   assign issue          = (|req_valid_i) & ~fifo_full & ~flush_i;
   assign accept         = issue & div_in_ready_i;
   assign div_in_valid_o = issue;
   assign div_operands_o = sel_ops;
   assign div_flush_o    = flush_i;
   assign rsp_result_o   = div_result_i;
   assign rsp_status_o   = div_status_i;
   assign busy_o         = ~fifo_empty | hold_q | div_busy_i;
   assign err_o          = err_q;

   // Operand mux and one-hot accept strobe for the granted requester
   always_comb begin
      sel_ops     = '0;
      req_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == req_id_t'(i)) begin
            if (issue) sel_ops = req_operands_i[i*OPERAND_W +: OPERAND_W];
            req_ready_o[i] = accept;
         end
      end
   end

   // Result steering: head of the ID FIFO owns the divider output
   always_comb begin
      rsp_valid_o     = '0;
      div_out_ready_o = 1'b0;
      pop             = 1'b0;
      orphan          = 1'b0;
      if (flush_i) begin
         div_out_ready_o = 1'b1;
      end else if (!fifo_empty) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (head_id == req_id_t'(i)) begin
               rsp_valid_o[i]  = div_out_valid_i;
               div_out_ready_o = rsp_ready_i[i];
            end
         end
         pop = div_out_valid_i & div_out_ready_o;
      end else begin
         // nobody owns this result: sink it and flag the error
         div_out_ready_o = div_out_valid_i;
         orphan          = div_out_valid_i;
      end
   end

   // Round-robin pointer, grant hold while the divider stalls, sticky error
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q      <= '0;
         hold_q    <= 1'b0;
         hold_id_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            if (grant == req_id_t'(NUM_REQ-1)) rr_q <= '0;
            else                               rr_q <= grant + 1'b1;
         end
         if (flush_i || accept) begin
            hold_q <= 1'b0;
         end else if (issue) begin
            hold_q    <= 1'b1;
            hold_id_q <= grant;
         end
         if (orphan) err_q <= 1'b1;
      end
   end

   cdiv_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH ($bits(req_id_t))
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (flush_i),
      .push_i  (accept),
      .data_i  (grant),
      .pop_i   (pop),
      .data_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef CDIV_ARB_STATS_EN
   logic [NUM_REQ-1:0][31:0] acc_cnt_q;

   // Saturating per-requester accept counters, untouched by flush
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready_o[i] && (acc_cnt_q[i] != '1)) acc_cnt_q[i] <= acc_cnt_q[i] + 1'b1;
         end
      end
   end

   assign acc_cnt_o = acc_cnt_q;
`else
   // statistics disabled: no counters, no acc_cnt_o port
`endif

endmodule

// File: doc/cdiv_arbiter.md
# cdiv_arbiter

Shares one `complex_div` instance between NUM_REQ independent requesters, such as the triangular inverse engine, a back-substitution unit and a normaliser. Grants are issued round-robin. Each accepted request's requester ID is recorded in an in-order ID FIFO, and each divider result is routed back to the requester that issued it. The block sits between the requesters and the divider and also owns the divider's flush and ready signals.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MAX_OUTSTANDING, 4, ID FIFO depth, i.e. maximum divisions in flight (power of two, ≥2)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_operands_i  in  NUM_REQ×4×64  per-requester operands {b2,a2,b1,a1}, IEEE double
- req_valid_i  in  NUM_REQ  request valid
- req_ready_o  out  NUM_REQ  request accepted this cycle
- rsp_result_o  out  2×64  shared result bus {b,a}
- rsp_status_o  out  5  fpnew status flags of the result
- rsp_valid_o  out  NUM_REQ  one-hot result valid, addressed to the owning requester
- rsp_ready_i  in  NUM_REQ  requester result ready
- div_operands_o  out  4×64  to divider operands_i
- div_in_valid_o / div_in_ready_i  out/in  1  divider input handshake
- div_result_i, div_status_i  in  2×64, 5  from divider
- div_out_valid_i / div_out_ready_o  in/out  1  divider output handshake
- div_busy_i  in  1  divider busy
- flush_i  in  1  flush request; div_flush_o  out  1  flush to divider
- busy_o  out  1  work outstanding
- err_o  out  1  sticky: divider result arrived with no ID in the FIFO

## Operation
- Arbitration pointer rr_q. The grant goes to the first valid requester at or after rr_q, modulo NUM_REQ.
- Issue condition: any req_valid_i, ID FIFO not full, and flush_i low. When it holds, div_in_valid_o=1 and div_operands_o = operands of the granted requester.
- Grant hold: if div_in_valid_o=1 and div_in_ready_i=0, latch hold_q=1 and hold_id_q=grant. The grant stays on hold_id_q until accepted. Requesters must keep valid and operands stable until ready.
- Accept (div_in_valid_o & div_in_ready_i):
  - req_ready_o[grant]=1
  - push grant ID into the FIFO
  - rr_q ← grant+1, wrapping at NUM_REQ-1→0
  - clear hold_q
- Response: with the FIFO non-empty and head=h:
  - rsp_valid_o[h] = div_out_valid_i
  - div_out_ready_o = rsp_ready_i[h]
  - pop on div_out_valid_i & div_out_ready_o
  - rsp_result_o and rsp_status_o pass straight through.
- Empty FIFO with div_out_valid_i=1: div_out_ready_o=1, the result is discarded, err_o is set. err_o clears only on reset.
- Push and pop in the same cycle: occupancy unchanged. A push while full cannot occur because the issue condition is gated.
- Flush: div_flush_o=flush_i. While flush_i is high:
  - no issue; all rsp_valid_o=0; div_out_ready_o=1
  - next cycle the FIFO is emptied and hold_q cleared
  - rr_q and err_o are unchanged.
- busy_o = FIFO non-empty | hold_q | div_busy_i.

## Timing
- Reset values:
  - all outputs 0, including req_ready_o, rsp_valid_o, div_in_valid_o, div_out_ready_o, busy_o and err_o
  - rr_q=0, FIFO empty, hold_q=0.
- Request path has zero latency: req_valid_i in cycle t gives div_in_valid_o in cycle t.
- Response path has zero latency: div_out_valid_i in cycle t gives rsp_valid_o in cycle t.
- FIFO occupancy updates at the clock edge after a push or pop.
- A reset asserted mid-operation clears all state asynchronously. In-flight results arriving afterwards with an empty FIFO set err_o, so the divider must be reset together with this block.

## Configuration
- CDIV_ARB_STATS_EN defined: adds output acc_cnt_o (NUM_REQ×32).
  - Per-requester accepted-request counters, incremented on accept, saturating at 2^32-1.
  - Reset to 0 and not cleared by flush.
- CDIV_ARB_STATS_EN undefined: the port and counters are absent. No other behavioural difference.

## Structure
- Package cdiv_arb_pkg holds:
  - operand_t (4×64) and result_t (2×64)
  - STATUS_W=5
  - req_id_t, defined as logic [$clog2(NUM_REQ_MAX)-1:0] with NUM_REQ_MAX=8
- Sub-module cdiv_id_fifo: synchronous FIFO with parameterised depth and width, push/pop/clear, full/empty, simultaneous push and pop. Instantiated once.

## Test plan
- Single requester 0 sends 1.0/2.0 with the divider stalled 3 cycles → div_in_valid_o held with stable operands for 3 cycles, then req_ready_o[0] pulses once, FIFO occupancy becomes 1, and rsp_valid_o=4'b0001 when the result returns.
- All 4 requesters valid continuously, divider always ready → grant order 0,1,2,3,0,… with rr_q wrap, and each requester receives its own results in issue order.
- Requester 2 holds rsp_ready_i=0 for 5 cycles while at the FIFO head → div_out_ready_o=0 for those cycles, no other rsp_valid_o bit asserts, and the other requesters are still issued until the FIFO reaches MAX_OUTSTANDING=4, at which point issue stops.
- flush_i pulsed with 3 ops in flight → div_flush_o pulses, the FIFO is empty the next cycle, no rsp_valid_o during the flush cycle, and busy_o falls once div_busy_i=0.
- div_out_valid_i injected with the FIFO empty → div_out_ready_o=1, no rsp_valid_o, err_o=1 and it stays high.
- With CDIV_ARB_STATS_EN: 10 accepts from requester 1 and 3 from requester 3 → acc_cnt_o = {3,0,10,0}, index 3 down to 0.
